// File: rtl/enc_dec_roundtrip_pkg.sv
// Shared constants and the 2-bit lane code type used by the encoder/decoder round trip.
package enc_dec_roundtrip_pkg;

  localparam int CODE_W  = 2;
  localparam int N_LANES = 4;

  typedef enum logic [CODE_W-1:0] {
    CODE_L1 = 2'b00,
    CODE_L2 = 2'b01,
    CODE_L3 = 2'b10,
    CODE_L4 = 2'b11
  } code_e;

  function automatic code_e lane_to_code(input int lane);
    return code_e'(CODE_W'(lane));
  endfunction

endpackage

// File: rtl/enc_dec_roundtrip_dec2to4.sv
// Combinational 2-to-4 one-hot decoder; all lines stay low when the code is not valid.
import enc_dec_roundtrip_pkg::*;

module onehot_dec2to4 (
  input  logic                code_valid,
  input  code_e               code,
  output logic [N_LANES-1:0]  lines
);

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_line
    assign lines[gi] = code_valid && (code == lane_to_code(gi));
  end

endmodule

// File: rtl/enc_dec_roundtrip.sv
// Two-stage pipeline: priority-encode four request lines into a registered 2-bit code,
// then decode it back into registered one-hot grant lines.
import enc_dec_roundtrip_pkg::*;

module enc_dec_roundtrip #(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  output logic y1,
  output logic y2,
  output logic valid,
  output logic err,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic g4
);

  logic [N_LANES-1:0] req;
  code_e              code_next;
  logic               valid_next;
  logic               err_next;

  code_e              code_reg;
  logic               valid_reg;
  logic               err_reg;
  logic [N_LANES-1:0] dec_lines;
  logic [N_LANES-1:0] g_reg;

  assign req = {i4, i3, i2, i1};

  // Scan order decides the winner: the last set lane visited overwrites earlier ones.
  always_comb begin
    code_next = CODE_L1;
    if (LSB_PRIORITY) begin
      for (int k = N_LANES - 1; k >= 0; k--) begin
        if (req[k]) code_next = lane_to_code(k);
      end
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        if (req[k]) code_next = lane_to_code(k);
      end
    end
  end

  assign valid_next = |req;
  assign err_next   = |(req & (req - N_LANES'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      code_reg  <= CODE_L1;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      g_reg     <= '0;
    end else begin
      code_reg  <= code_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      g_reg     <= dec_lines;
    end
  end

  onehot_dec2to4 u_dec (
    .code_valid (valid_reg),
    .code       (code_reg),
    .lines      (dec_lines)
  );

  assign y1    = code_reg[1];
  assign y2    = code_reg[0];
  assign valid = valid_reg;
  assign err   = err_reg;
  assign g1    = g_reg[0];
  assign g2    = g_reg[1];
  assign g3    = g_reg[2];
  assign g4    = g_reg[3];

endmodule

// File: tb/tb_enc_dec_roundtrip.sv
// Scoreboard bench: stimulus pushes expected per-edge outputs for both priority variants,
// a monitor pops and compares one entry per clock edge.
module tb_enc_dec_roundtrip;

  typedef struct {
    logic [1:0] y;
    logic       v;
    logic       e;
    logic [3:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic i1, i2, i3, i4;
  logic y1_0, y2_0, v_0, e_0, g1_0, g2_0, g3_0, g4_0;
  logic y1_1, y2_1, v_1, e_1, g1_1, g2_1, g3_1, g4_1;

  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] pend_g0, pend_g1;
  int total = 0;
  int bad   = 0;
  int txn   = 0;

  always #5 clk = ~clk;

  enc_dec_roundtrip #(.LSB_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .y1(y1_0), .y2(y2_0), .valid(v_0), .err(e_0),
    .g1(g1_0), .g2(g2_0), .g3(g3_0), .g4(g4_0)
  );

  enc_dec_roundtrip #(.LSB_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .y1(y1_1), .y2(y2_1), .valid(v_1), .err(e_1),
    .g1(g1_1), .g2(g2_1), .g3(g3_1), .g4(g4_1)
  );

  // Reference: count the set lanes, pick the winner lane index, code = index, grant = 1<<index.
  function automatic void ref_model(input logic [3:0] iv, input bit lsb,
                                    output logic [1:0] y, output logic v,
                                    output logic e, output logic [3:0] g);
    int cnt = 0;
    int win = -1;
    for (int k = 0; k < 4; k++) begin
      if (iv[k]) begin
        cnt++;
        if (!lsb || win < 0) win = k;
      end
    end
    v = (cnt > 0);
    e = (cnt > 1);
    y = v ? 2'(win) : 2'b00;
    g = v ? 4'(1 << win) : 4'b0000;
  endfunction

  // Apply one cycle of input and push what each DUT must show after the next edge.
  task automatic issue(input logic r, input logic [3:0] iv);
    exp_t x0, x1;
    logic [1:0] y;
    logic v, e;
    logic [3:0] g;
    rst = r;
    {i4, i3, i2, i1} = iv;
    x0.g = r ? 4'b0000 : pend_g0;
    x1.g = r ? 4'b0000 : pend_g1;
    ref_model(iv, 1'b0, y, v, e, g);
    x0.y = r ? 2'b00 : y; x0.v = r ? 1'b0 : v; x0.e = r ? 1'b0 : e;
    pend_g0 = r ? 4'b0000 : g;
    ref_model(iv, 1'b1, y, v, e, g);
    x1.y = r ? 2'b00 : y; x1.v = r ? 1'b0 : v; x1.e = r ? 1'b0 : e;
    pend_g1 = r ? 4'b0000 : g;
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  task automatic step(input logic r, input logic [3:0] iv);
    @(negedge clk);
    issue(r, iv);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s txn=%0d got=%b want=%b", name, txn, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one scoreboard entry is consumed per edge.
  initial begin
    exp_t a, b;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        a = q0.pop_front();
        b = q1.pop_front();
        txn++;
        check("p0_y",   {2'b00, y1_0, y2_0}, {2'b00, a.y});
        check("p0_vld", {3'b000, v_0}, {3'b000, a.v});
        check("p0_err", {3'b000, e_0}, {3'b000, a.e});
        check("p0_g",   {g4_0, g3_0, g2_0, g1_0}, a.g);
        check("p1_y",   {2'b00, y1_1, y2_1}, {2'b00, b.y});
        check("p1_vld", {3'b000, v_1}, {3'b000, b.v});
        check("p1_err", {3'b000, e_1}, {3'b000, b.e});
        check("p1_g",   {g4_1, g3_1, g2_1, g1_1}, b.g);
        $display("txn %0d rst=%b i=%b%b%b%b p0:y=%b%b v=%b e=%b g=%b%b%b%b p1:y=%b%b v=%b e=%b g=%b%b%b%b",
                 txn, rst, i4, i3, i2, i1, y1_0, y2_0, v_0, e_0, g4_0, g3_0, g2_0, g1_0,
                 y1_1, y2_1, v_1, e_1, g4_1, g3_1, g2_1, g1_1);
      end
    end
  end

  initial begin
    pend_g0 = 4'b0000;
    pend_g1 = 4'b0000;
    issue(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    for (int rep = 0; rep < 2; rep++) begin
      for (int lane = 0; lane < 4; lane++) begin
        for (int c = 0; c < 10; c++) step(1'b0, 4'(1 << lane));
      end
    end
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0100);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0000);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0101);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1000);
    step(1'b1, 4'b1000);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0000);
    for (int c = 0; c < 300; c++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 3; c++) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
